// File: rtl/mf7_frame_accum.sv
// mf7_frame_accum: decodes 7-bit minifloat codes {exp[2:0], man[3:0]} back to
// 11-bit unsigned integers and sums them over a frame of FRAME_LEN samples
// (or fewer when in_last closes the frame early). The frame result is held on
// a valid/ready output until accepted; one bubble separates frames.
// Optional feature macro: MF7_ACC_MAX_EN adds out_max (per-frame peak value).
module mf7_frame_accum #(
  parameter int FRAME_LEN = 16,
  parameter int ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [8:0]       out_cnt
`ifdef MF7_ACC_MAX_EN
  ,
  output logic [10:0]      out_max
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [8:0] FL = 9'(FRAME_LEN);

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [8:0]       cnt_q, cnt_d;
  logic [10:0]      dec_val;
  logic [ACC_W-1:0] dec_ext;
  logic [8:0]       cnt_inc;
  logic             accept;

  // Minifloat decode: denormal range passes the mantissa through, otherwise
  // the implicit leading one is restored and shifted by exp-1.
  always_comb begin
    dec_val = 11'd0;
    if (in_code[6:4] == 3'd0) dec_val = {7'd0, in_code[3:0]};
    else                      dec_val = {6'd0, 1'b1, in_code[3:0]} << (in_code[6:4] - 3'd1);
  end

  assign dec_ext  = ACC_W'(dec_val);
  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;
  assign cnt_inc  = cnt_q + 9'd1;

`ifdef MF7_ACC_MAX_EN
  logic [10:0] max_q, max_d;
`endif

  // Next-state: frame accumulation, early close on in_last, HOLD until handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef MF7_ACC_MAX_EN
    max_d   = max_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = dec_ext;
          cnt_d   = 9'd1;
`ifdef MF7_ACC_MAX_EN
          max_d   = dec_val;
`endif
          state_d = (in_last || FL == 9'd1) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q + dec_ext;
          cnt_d = cnt_inc;
`ifdef MF7_ACC_MAX_EN
          if (dec_val > max_q) max_d = dec_val;
`endif
          if (in_last || cnt_inc == FL) state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = 9'd0;
`ifdef MF7_ACC_MAX_EN
          max_d   = 11'd0;
`endif
          state_d = IDLE;
        end
      end
      default: begin
        acc_d   = '0;
        cnt_d   = 9'd0;
`ifdef MF7_ACC_MAX_EN
        max_d   = 11'd0;
`endif
        state_d = IDLE;
      end
    endcase
  end

  // State and accumulator registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= 9'd0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MF7_ACC_MAX_EN
  // Running peak of the decoded values in the current frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) max_q <= 11'd0;
    else        max_q <= max_d;
  end
  assign out_max = max_q;
`endif

  assign out_valid = (state_q == HOLD);
  assign out_sum   = acc_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_mf7_frame_accum.sv
// Directed bench for mf7_frame_accum: full frame, early end, backpressure,
// gapped input, reset mid-frame and accumulator wrap (second instance, ACC_W=11).
// Honours MF7_ACC_MAX_EN for the out_max checks.
module tb_mf7_frame_accum;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [6:0]  in_code;
  logic        in_ready, out_valid;
  logic [15:0] out_sum;
  logic [8:0]  out_cnt;
`ifdef MF7_ACC_MAX_EN
  logic [10:0] out_max;
  logic [10:0] w_max;
`endif

  logic        w_valid, w_last, w_oready;
  logic [6:0]  w_code;
  logic        w_iready, w_ovalid;
  logic [10:0] w_sum;
  logic [8:0]  w_cnt;

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;

  always #5 clk = ~clk;

  mf7_frame_accum #(.FRAME_LEN(16), .ACC_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cnt(out_cnt)
`ifdef MF7_ACC_MAX_EN
    , .out_max(out_max)
`endif
  );

  mf7_frame_accum #(.FRAME_LEN(2), .ACC_W(11)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .in_valid(w_valid), .in_ready(w_iready), .in_code(w_code), .in_last(w_last),
    .out_valid(w_ovalid), .out_ready(w_oready), .out_sum(w_sum), .out_cnt(w_cnt)
`ifdef MF7_ACC_MAX_EN
    , .out_max(w_max)
`endif
  );

  // Output handshakes of the main instance.
  always @(posedge clk) if (rst_n && out_valid && out_ready) hs_cnt <= hs_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One accepted beat on the main instance (caller ensures in_ready is high).
  task automatic beat(input logic [6:0] code, input logic last);
    in_valid = 1'b1; in_code = code; in_last = last;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  initial begin
    int hs0, n, cyc;
    logic v, ir;
    rst_n = 1'b0; in_valid = 0; in_last = 0; in_code = '0; out_ready = 0;
    w_valid = 0; w_last = 0; w_code = '0; w_oready = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum",   32'(out_sum),   32'd0);
    chk("rst_out_cnt",   32'(out_cnt),   32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
`ifdef MF7_ACC_MAX_EN
    chk("rst_out_max",   32'(out_max),   32'd0);
`endif

    // 1. Full frame of 16 x 0x7F with out_ready held high
    out_ready = 1'b1; hs0 = hs_cnt;
    for (int i = 0; i < 15; i++) beat(7'h7F, 1'b0);
    chk("t1_no_early_valid", 32'(out_valid), 32'd0);
    chk("t1_cnt15",          32'(out_cnt),   32'd15);
    beat(7'h7F, 1'b0);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_sum",   32'(out_sum),   32'd31744);
    chk("t1_cnt",   32'(out_cnt),   32'd16);
`ifdef MF7_ACC_MAX_EN
    chk("t1_max",   32'(out_max),   32'd1984);
`endif
    tick();
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_one_pulse",  32'(hs_cnt - hs0), 32'd1);
    chk("t1_cleared",    32'(out_sum),   32'd0);

    // 2+3. Early end then 5 cycles of backpressure with junk on the input
    out_ready = 1'b0; hs0 = hs_cnt;
    beat(7'h0F, 1'b0);
    beat(7'h10, 1'b0);
    beat(7'h20, 1'b1);
    chk("t2_valid",    32'(out_valid), 32'd1);
    chk("t2_sum",      32'(out_sum),   32'd63);
    chk("t2_cnt",      32'(out_cnt),   32'd3);
    chk("t2_in_ready", 32'(in_ready),  32'd0);
`ifdef MF7_ACC_MAX_EN
    chk("t2_max",      32'(out_max),   32'd32);
`endif
    in_valid = 1'b1; in_code = 7'h7F; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3_hold_valid",    32'(out_valid), 32'd1);
      chk("t3_hold_sum",      32'(out_sum),   32'd63);
      chk("t3_hold_cnt",      32'(out_cnt),   32'd3);
      chk("t3_hold_in_ready", 32'(in_ready),  32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3_release_valid", 32'(out_valid), 32'd0);
    chk("t3_release_ready", 32'(in_ready),  32'd1);
    chk("t3_one_hs",        32'(hs_cnt - hs0), 32'd1);
    out_ready = 1'b0;

    // 4. Gapped input, 16 x 0x01
    n = 0; cyc = 0;
    while (n < 16 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      in_valid = v; in_code = 7'h01; in_last = 1'b0;
      ir = in_ready;
      tick();
      if (v && ir) n++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("t4_no_timeout", 32'(n), 32'd16);
    chk("t4_valid", 32'(out_valid), 32'd1);
    chk("t4_sum",   32'(out_sum),   32'd16);
    chk("t4_cnt",   32'(out_cnt),   32'd16);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t4_done", 32'(out_valid), 32'd0);

    // 5. Reset mid-frame after 7 accepts, then a fresh frame of 16 x 0x05
    for (int i = 0; i < 7; i++) beat(7'h05, 1'b0);
    chk("t5_partial_cnt", 32'(out_cnt), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_cnt",   32'(out_cnt),  32'd0);
    chk("t5_async_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_post_rst_sum", 32'(out_sum), 32'd0);
    for (int i = 0; i < 16; i++) beat(7'h05, 1'b0);
    chk("t5_valid", 32'(out_valid), 32'd1);
    chk("t5_sum",   32'(out_sum),   32'd80);
    chk("t5_cnt",   32'(out_cnt),   32'd16);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // 6. Wrap on the ACC_W=11, FRAME_LEN=2 instance
    w_valid = 1'b1; w_code = 7'h7F;
    tick();
    chk("t6_first_not_done", 32'(w_ovalid), 32'd0);
    tick();
    w_valid = 1'b0;
    chk("t6_valid", 32'(w_ovalid), 32'd1);
    chk("t6_sum",   32'(w_sum),    32'd1920);
    chk("t6_cnt",   32'(w_cnt),    32'd2);
    w_oready = 1'b1; tick(); w_oready = 1'b0;
    chk("t6_done",  32'(w_ovalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
